// File: rtl/pad_test_pkg.sv
// pad_test_pkg
// Shared definitions for the pad-test loopback checker and its bench.
//   - FSM state enumeration for the checker
//   - 13-bit LFSR width and Galois tap mask (x^13+x^4+x^3+x+1)
//   - pad counts on each side of the loopback link
//   - exp_rsp(): the fixed pad-test mapping from stimulus to expected response
package pad_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } pad_state_e;

  localparam int          LFSR_W    = 13;
  // Low-order terms of the polynomial; x^13 is the bit shifted out of bit 12.
  localparam logic [12:0] LFSR_TAPS = 13'h001B;

  localparam int STIM_GPIO_W = 8;   // drives DUT gpio15..8
  localparam int STIM_HIP_W  = 5;   // drives DUT hip7..3
  localparam int RSP_GPIO_W  = 8;   // from DUT gpio7..0
  localparam int RSP_HIP_W   = 3;   // from DUT hip2..0
  localparam int RSP_W       = RSP_GPIO_W + RSP_HIP_W;

  // Expected DUT response {gpio7..0, hip2..0} for a given stimulus.
  // gpio0 is a registered path inside the DUT; the value is the same, it just
  // needs one extra cycle to appear.
  function automatic logic [RSP_W-1:0] exp_rsp(
    input logic [STIM_GPIO_W-1:0] stim_gpio,
    input logic [STIM_HIP_W-1:0]  stim_hip
  );
    logic [RSP_GPIO_W-1:0] g;
    logic [RSP_HIP_W-1:0]  h;
    g[7:3] = stim_gpio[4:0];
    g[2]   = stim_hip[4];
    g[1]   = stim_hip[3];
    g[0]   = stim_gpio[7] ^ stim_gpio[6] ^ stim_gpio[5];
    h      = stim_hip[2:0];
    return {g, h};
  endfunction

endpackage

// File: rtl/pad_lfsr13.sv
// pad_lfsr13
// 13-bit Galois LFSR (x^13+x^4+x^3+x+1), shifting left with feedback from bit 12.
// A SEED of zero would lock the register, so it is replaced by 13'h0001.
// Ports:
//   gclk        in   clock, rising edge
//   resetn      in   synchronous active-low reset (register returns to the seed)
//   load        in   load the seed on the next edge
//   step        in   advance one state on the next edge
//   value       out  current LFSR state
//   value_next  out  state the register takes on the next edge
module pad_lfsr13
  import pad_test_pkg::*;
#(
  parameter logic [12:0] SEED = 13'h1ACE
) (
  input  logic              gclk,
  input  logic              resetn,
  input  logic              load,
  input  logic              step,
  output logic [LFSR_W-1:0] value,
  output logic [LFSR_W-1:0] value_next
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 13'h0000) ? 13'h0001 : SEED;

  logic [LFSR_W-1:0] shifted;

  // Next-state selection: load wins over step, otherwise hold
  always_comb begin
    shifted = {value[LFSR_W-2:0], 1'b0} ^ (value[LFSR_W-1] ? LFSR_TAPS : 13'h0000);
    if (load) begin
      value_next = SEED_EFF;
    end else if (step) begin
      value_next = shifted;
    end else begin
      value_next = value;
    end
  end

  // LFSR state register
  always_ff @(posedge gclk) begin
    if (!resetn) begin
      value <= SEED_EFF;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/pad_loopback_checker.sv
// pad_loopback_checker
// Tester-side stimulus generator and response checker for the pad-test build.
// Drives LFSR vectors onto the DUT input pads, holds each for HOLD cycles and
// compares the DUT output pads against the fixed pad-test mapping on the last
// hold cycle of every vector.
// Parameters:
//   NUM_VECTORS  vectors per run (1..65535)
//   HOLD         cycles each vector is held (2..255)
//   SEED         initial LFSR value (0 is replaced by 13'h0001)
// Ports:
//   gclk        in   sole clock, rising edge
//   resetn      in   synchronous active-low reset; aborts a run without done
//   start       in   one-cycle run request, honoured only in IDLE
//   stim_gpio   out  to DUT gpio15..8 (bit 7 = gpio15), 0 outside DRIVE
//   stim_hip    out  to DUT hip7..3 (bit 4 = hip7), 0 outside DRIVE
//   rsp_gpio    in   from DUT gpio7..0
//   rsp_hip     in   from DUT hip2..0
//   busy        out  high while vectors are being driven
//   done        out  one-cycle pulse at end of run (busy already low)
//   pass        out  1 iff err_count==0, valid from done until next start
//   err_count   out  failing vectors, saturating at 255
//   first_fail  out  index of the first failing vector, 16'hFFFF if none
//   fail_mask   out  sticky per-bit mismatch {rsp_gpio, rsp_hip}
// Build option:
//   PADCHK_FAIL_MASK_EN  when defined, fail_mask accumulates mismatches;
//                        otherwise it is tied to 0 and no flops are built.
module pad_loopback_checker
  import pad_test_pkg::*;
#(
  parameter int          NUM_VECTORS = 256,
  parameter int          HOLD        = 4,
  parameter logic [12:0] SEED        = 13'h1ACE
) (
  input  logic                   gclk,
  input  logic                   resetn,
  input  logic                   start,
  output logic [STIM_GPIO_W-1:0] stim_gpio,
  output logic [STIM_HIP_W-1:0]  stim_hip,
  input  logic [RSP_GPIO_W-1:0]  rsp_gpio,
  input  logic [RSP_HIP_W-1:0]   rsp_hip,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [7:0]             err_count,
  output logic [15:0]            first_fail,
  output logic [RSP_W-1:0]       fail_mask
);

  localparam logic [1:0]  S_IDLE    = ST_IDLE;
  localparam logic [1:0]  S_DRIVE   = ST_DRIVE;
  localparam logic [1:0]  S_DONE    = ST_DONE;
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD - 1);
  localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] NO_FAIL   = 16'hFFFF;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [7:0]        hold_cnt;
  logic [15:0]       vec_idx;
  logic              lfsr_load;
  logic              lfsr_step;
  logic              compare_now;
  logic [LFSR_W-1:0] lfsr_value;
  logic [LFSR_W-1:0] lfsr_value_next;
  logic [RSP_W-1:0]  expected;
  logic [RSP_W-1:0]  mismatch;
  logic              vec_fail;
  logic [7:0]        err_next;

  pad_lfsr13 #(
    .SEED (SEED)
  ) u_lfsr (
    .gclk       (gclk),
    .resetn     (resetn),
    .load       (lfsr_load),
    .step       (lfsr_step),
    .value      (lfsr_value),
    .value_next (lfsr_value_next)
  );

  // FSM next state plus the load/step/compare strobes for this cycle
  always_comb begin
    state_next  = state;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    compare_now = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_DRIVE;
          lfsr_load  = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (hold_cnt == HOLD_LAST) begin
          compare_now = 1'b1;
          lfsr_step   = 1'b1;
          if (vec_idx == LAST_IDX) begin
            state_next = S_DONE;
          end else begin
            state_next = S_DRIVE;
          end
        end else begin
          state_next = S_DRIVE;
        end
      end
      // A start arriving here is deliberately dropped.
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Expected response for the vector on the pads; in DRIVE the LFSR state is
  // exactly what the stim registers are presenting.
  always_comb begin
    expected = exp_rsp(lfsr_value[12:5], lfsr_value[4:0]);
    mismatch = expected ^ {rsp_gpio, rsp_hip};
    vec_fail = |mismatch;
  end

  // Saturating error count after this cycle's compare
  always_comb begin
    if (compare_now && vec_fail && (err_count != 8'hFF)) begin
      err_next = err_count + 8'd1;
    end else begin
      err_next = err_count;
    end
  end

  // FSM state, hold counter and vector index
  always_ff @(posedge gclk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      hold_cnt <= 8'd0;
      vec_idx  <= 16'd0;
    end else begin
      state <= state_next;
      if (lfsr_load) begin
        hold_cnt <= 8'd0;
        vec_idx  <= 16'd0;
      end else if (compare_now) begin
        hold_cnt <= 8'd0;
        vec_idx  <= vec_idx + 16'd1;
      end else if (state == S_DRIVE) begin
        hold_cnt <= hold_cnt + 8'd1;
      end else begin
        hold_cnt <= hold_cnt;
      end
    end
  end

  // Registered pad drive and status strobes, decoded from the next state so
  // they line up with the FSM
  always_ff @(posedge gclk) begin
    if (!resetn) begin
      stim_gpio <= 8'h00;
      stim_hip  <= 5'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (state_next == S_DRIVE) begin
        stim_gpio <= lfsr_value_next[12:5];
        stim_hip  <= lfsr_value_next[4:0];
      end else begin
        stim_gpio <= 8'h00;
        stim_hip  <= 5'h00;
      end
      busy <= (state_next == S_DRIVE);
      done <= (state_next == S_DONE);
    end
  end

  // Run results: cleared on an accepted start, updated at each compare,
  // held otherwise so they stay readable after the run
  always_ff @(posedge gclk) begin
    if (!resetn) begin
      err_count  <= 8'h00;
      first_fail <= NO_FAIL;
      pass       <= 1'b0;
    end else if (lfsr_load) begin
      err_count  <= 8'h00;
      first_fail <= NO_FAIL;
      pass       <= 1'b0;
    end else if (compare_now) begin
      err_count <= err_next;
      if (vec_fail && (first_fail == NO_FAIL)) begin
        first_fail <= vec_idx;
      end else begin
        first_fail <= first_fail;
      end
      if (state_next == S_DONE) begin
        pass <= (err_next == 8'h00);
      end else begin
        pass <= pass;
      end
    end else begin
      err_count  <= err_count;
      first_fail <= first_fail;
      pass       <= pass;
    end
  end

`ifdef PADCHK_FAIL_MASK_EN
  logic [RSP_W-1:0] mask_acc;

  // Sticky OR of the mismatch bits seen at every compare
  always_ff @(posedge gclk) begin
    if (!resetn) begin
      mask_acc <= 11'h000;
    end else if (lfsr_load) begin
      mask_acc <= 11'h000;
    end else if (compare_now) begin
      mask_acc <= mask_acc | mismatch;
    end else begin
      mask_acc <= mask_acc;
    end
  end

  assign fail_mask = mask_acc;
`else
  assign fail_mask = 11'h000;
`endif

endmodule

// File: tb/tb_pad_loopback_checker.sv
// tb_pad_loopback_checker
// Two checker instances are exercised against an emulated pad-test DUT with
// selectable faults: instance 0 (16 vectors, HOLD=4, default seed) and
// instance 1 (300 vectors, HOLD=2, SEED=0). A cycle-level model derived from
// the run rules (edge counting, polynomial LFSR stepping) predicts every
// output; literal expectations pin the model and the key scenarios.
`timescale 1ns/1ps
module tb_pad_loopback_checker;
  import pad_test_pkg::*;

  logic        gclk = 1'b0;
  logic        resetn;
  logic        start      [2];
  logic [7:0]  stim_gpio  [2];
  logic [4:0]  stim_hip   [2];
  logic [10:0] rsp_all    [2];
  logic        busy       [2];
  logic        done       [2];
  logic        pass       [2];
  logic [7:0]  err_count  [2];
  logic [15:0] first_fail [2];
  logic [10:0] fail_mask  [2];
  logic        reg_bit    [2];
  int          fmode      [2];   // 0 ideal, 1 gpio0 stuck 0, 2 hip1/hip0 swapped, 3 hip0 inverted

  int          checks = 0;
  int          errors = 0;

  // Run geometry as seen by the model; SEED=0 is replaced by 1.
  int          pn [2] = '{16, 300};
  int          ph [2] = '{4, 2};
  logic [12:0] ps [2] = '{13'h1ACE, 13'h0001};

  always #5 gclk = ~gclk;

  pad_loopback_checker #(.NUM_VECTORS(16), .HOLD(4), .SEED(13'h1ACE)) u_dut0 (
    .gclk(gclk), .resetn(resetn), .start(start[0]),
    .stim_gpio(stim_gpio[0]), .stim_hip(stim_hip[0]),
    .rsp_gpio(rsp_all[0][10:3]), .rsp_hip(rsp_all[0][2:0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_count[0]), .first_fail(first_fail[0]), .fail_mask(fail_mask[0]));

  pad_loopback_checker #(.NUM_VECTORS(300), .HOLD(2), .SEED(13'h0000)) u_dut1 (
    .gclk(gclk), .resetn(resetn), .start(start[1]),
    .stim_gpio(stim_gpio[1]), .stim_hip(stim_hip[1]),
    .rsp_gpio(rsp_all[1][10:3]), .rsp_hip(rsp_all[1][2:0]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_count[1]), .first_fail(first_fail[1]), .fail_mask(fail_mask[1]));

  // Emulated pad-test DUT: wiring of the mapping, with an optional fault.
  function automatic logic [10:0] emu(input logic [7:0] sg, input logic [4:0] sh,
                                      input logic rb, input int mode);
    logic [7:0] g;
    logic [2:0] h;
    g = {sg[4:0], sh[4], sh[3], rb};
    h = sh[2:0];
    case (mode)
      1:       g[0] = 1'b0;
      2:       h    = {h[2], h[0], h[1]};
      3:       h[0] = ~h[0];
      default: h    = h;
    endcase
    return {g, h};
  endfunction

  // LFSR as multiplication by x modulo x^13+x^4+x^3+x+1.
  function automatic logic [12:0] lfsr_adv(input logic [12:0] v);
    logic [13:0] p;
    p = {v, 1'b0};
    if (p[13]) p = p ^ 14'h201B;
    return p[12:0];
  endfunction

  function automatic logic [12:0] lfsr_n(input logic [12:0] v, input int n);
    logic [12:0] r;
    r = v;
    for (int j = 0; j < n; j++) r = lfsr_adv(r);
    return r;
  endfunction

  // Independent whole-run tally: raw failure count and first failing index.
  function automatic int count_fails(input logic [12:0] seed, input int n,
                                     input int mode, output int first);
    logic [12:0] v;
    int          c;
    v = seed; c = 0; first = 65535;
    for (int k = 0; k < n; k++) begin
      if (emu(v[12:5], v[4:0], ^v[12:10], mode) != exp_rsp(v[12:5], v[4:0])) begin
        if (c == 0) first = k;
        c++;
      end
      v = lfsr_adv(v);
    end
    return c;
  endfunction

  assign rsp_all[0] = emu(stim_gpio[0], stim_hip[0], reg_bit[0], fmode[0]);
  assign rsp_all[1] = emu(stim_gpio[1], stim_hip[1], reg_bit[1], fmode[1]);

  // Registered gpio0 path of the emulated DUT
  always @(posedge gclk) begin
    reg_bit[0] <= ^stim_gpio[0][7:5];
    reg_bit[1] <= ^stim_gpio[1][7:5];
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_known = 1'b0;
  bit          m_run  [2];
  bit          m_done [2];
  bit          m_pass [2];
  int          m_c    [2];
  logic [12:0] m_lfsr [2];
  logic [7:0]  m_err  [2];
  logic [15:0] m_ff   [2];
  logic [10:0] m_mask [2];

  task automatic model_step(input int i, input logic rs, input logic st);
    logic [10:0] mism;
    bit          done_old;
    int          k;
    if (!rs) begin
      m_run[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0;
      m_err[i] = 8'h00; m_ff[i] = 16'hFFFF; m_mask[i] = 11'h000;
    end else begin
      done_old  = m_done[i];
      m_done[i] = 1'b0;
      if (m_run[i]) begin
        m_c[i]++;
        if (m_c[i] % ph[i] == 0) begin
          k    = m_c[i] / ph[i] - 1;
          mism = exp_rsp(m_lfsr[i][12:5], m_lfsr[i][4:0]) ^
                 emu(m_lfsr[i][12:5], m_lfsr[i][4:0], ^m_lfsr[i][12:10], fmode[i]);
          if (mism != 11'h000) begin
            if (m_err[i] != 8'hFF) m_err[i] = m_err[i] + 8'd1;
            if (m_ff[i] == 16'hFFFF) m_ff[i] = 16'(k);
          end
          m_mask[i] = m_mask[i] | mism;
          m_lfsr[i] = lfsr_adv(m_lfsr[i]);
          if (k == pn[i] - 1) begin
            m_run[i]  = 1'b0;
            m_done[i] = 1'b1;
            m_pass[i] = (m_err[i] == 8'h00);
          end
        end
      end else if (!done_old && st) begin
        m_run[i] = 1'b1; m_c[i] = 0; m_lfsr[i] = ps[i];
        m_err[i] = 8'h00; m_ff[i] = 16'hFFFF; m_pass[i] = 1'b0; m_mask[i] = 11'h000;
      end
    end
  endtask

  // Compare process: advance the model on each edge, check all outputs 1ns later
  initial begin
    logic        rs;
    logic        st [2];
    logic [12:0] es;
    logic [10:0] em;
    forever begin
      @(posedge gclk);
      rs = resetn; st[0] = start[0]; st[1] = start[1];
      if (!rs) m_known = 1'b1;
      for (int i = 0; i < 2; i++) model_step(i, rs, st[i]);
      #1;
      if (m_known) begin
        for (int i = 0; i < 2; i++) begin
          es = m_run[i] ? m_lfsr[i] : 13'h0000;
`ifdef PADCHK_FAIL_MASK_EN
          em = m_mask[i];
`else
          em = 11'h000;
`endif
          chk("stim_gpio",  i, 32'(stim_gpio[i]),  32'(es[12:5]));
          chk("stim_hip",   i, 32'(stim_hip[i]),   32'(es[4:0]));
          chk("busy",       i, 32'(busy[i]),       32'(m_run[i]));
          chk("done",       i, 32'(done[i]),       32'(m_done[i]));
          chk("pass",       i, 32'(pass[i]),       32'(m_pass[i]));
          chk("err_count",  i, 32'(err_count[i]),  32'(m_err[i]));
          chk("first_fail", i, 32'(first_fail[i]), 32'(m_ff[i]));
          chk("fail_mask",  i, 32'(fail_mask[i]),  32'(em));
        end
      end
    end
  end

  // ---------------- directed sequence with random pokes ----------------
  task automatic pulse_start(input int i);
    @(negedge gclk); start[i] = 1'b1;
    @(negedge gclk); start[i] = 1'b0;
  endtask

  // Returns at the negedge of the done cycle; cyc=1 is the cycle after the start edge.
  task automatic wait_done(input int i, input int budget, output int cyc);
    cyc = 1;
    while (done[i] !== 1'b1 && cyc < budget) begin
      start[i] = ($urandom_range(0, 3) == 0);
      @(negedge gclk);
      cyc++;
    end
    if (done[i] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_done[%0d]: no done within %0d cycles", i, budget);
    end
  endtask

  task automatic chk_reset_vals(input int i);
    chk("rst_busy", i, 32'(busy[i]), 32'h0);
    chk("rst_done", i, 32'(done[i]), 32'h0);
    chk("rst_pass", i, 32'(pass[i]), 32'h0);
    chk("rst_err",  i, 32'(err_count[i]), 32'h0);
    chk("rst_ff",   i, 32'(first_fail[i]), 32'hFFFF);
    chk("rst_stim", i, {19'h0, stim_gpio[i], stim_hip[i]}, 32'h0);
    chk("rst_mask", i, 32'(fail_mask[i]), 32'h0);
  endtask

  initial begin
    int cyc;
    int cnt;
    int first;
    resetn = 1'b0; start[0] = 1'b0; start[1] = 1'b0; fmode[0] = 0; fmode[1] = 0;

    // Pin the model helpers with hand-computed values.
    chk("pin_exp_rsp_a", 0, 32'(exp_rsp(8'hE0, 5'h1A)), 32'h03A);
    chk("pin_exp_rsp_b", 0, 32'(exp_rsp(8'h1F, 5'h00)), 32'h7C0);
    chk("pin_lfsr_1ace", 0, 32'(lfsr_adv(13'h1ACE)), 32'h1587);
    chk("pin_lfsr_wrap", 0, 32'(lfsr_n(13'h0001, 13)), 32'h001B);

    repeat (3) @(negedge gclk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    resetn = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge gclk);

    // Ideal run on instance 0: done 65 cycles after start, clean result.
    pulse_start(0);
    wait_done(0, 100, cyc);
    chk("a_done_cycle", 0, 32'(cyc), 32'd65);
    chk("a_pass", 0, 32'(pass[0]), 32'h1);
    chk("a_err",  0, 32'(err_count[0]), 32'h0);
    chk("a_ff",   0, 32'(first_fail[0]), 32'hFFFF);
    chk("a_mask", 0, 32'(fail_mask[0]), 32'h0);
    chk("a_busy_in_done", 0, 32'(busy[0]), 32'h0);
    // Start during DONE is dropped; one cycle later it is accepted.
    start[0] = 1'b1;
    @(negedge gclk);
    chk("drop_in_done", 0, 32'(busy[0]), 32'h0);
    @(negedge gclk);
    start[0] = 1'b0;
    chk("accept_after_done", 0, 32'(busy[0]), 32'h1);
    chk("accept_pass_clr",   0, 32'(pass[0]), 32'h0);

    // Abort at cycle 20 of that run with resetn.
    repeat (19) @(negedge gclk);
    resetn = 1'b0;
    @(negedge gclk);
    chk_reset_vals(0);
    resetn = 1'b1;
    repeat (3) @(negedge gclk);
    chk("no_done_after_abort", 0, 32'(done[0]), 32'h0);

    // Clean run after the abort.
    pulse_start(0);
    wait_done(0, 100, cyc);
    chk("b_pass", 0, 32'(pass[0]), 32'h1);
    @(negedge gclk); start[0] = 1'b0;

    // gpio0 stuck at 0.
    fmode[0] = 1;
    cnt = count_fails(13'h1ACE, 16, 1, first);
    pulse_start(0);
    wait_done(0, 100, cyc);
    start[0] = 1'b0;
    chk("stuck_err",  0, 32'(err_count[0]), 32'(cnt));
    chk("stuck_ff",   0, 32'(first_fail[0]), 32'(first));
    chk("stuck_pass", 0, 32'(pass[0]), (cnt == 0) ? 32'h1 : 32'h0);
`ifdef PADCHK_FAIL_MASK_EN
    chk("stuck_mask", 0, 32'(fail_mask[0]), (cnt == 0) ? 32'h0 : 32'h008);
`else
    chk("stuck_mask", 0, 32'(fail_mask[0]), 32'h0);
`endif
    @(negedge gclk);
    fmode[0] = 0;

    // Instance 1, SEED=0: first vector is 00/01 and the run completes.
    pulse_start(1);
    chk("seed0_gpio", 1, 32'(stim_gpio[1]), 32'h00);
    chk("seed0_hip",  1, 32'(stim_hip[1]),  32'h01);
    wait_done(1, 700, cyc);
    start[1] = 1'b0;
    chk("c_done_cycle", 1, 32'(cyc), 32'd601);
    chk("c_pass", 1, 32'(pass[1]), 32'h1);
    @(negedge gclk);

    // hip1/hip0 swapped over 300 vectors.
    fmode[1] = 2;
    cnt = count_fails(13'h0001, 300, 2, first);
    pulse_start(1);
    wait_done(1, 700, cyc);
    start[1] = 1'b0;
    chk("swap_err",  1, 32'(err_count[1]), (cnt > 255) ? 32'd255 : 32'(cnt));
    chk("swap_ff",   1, 32'(first_fail[1]), 32'(first));
    chk("swap_pass", 1, 32'(pass[1]), 32'h0);
    @(negedge gclk);

    // Every vector fails: count saturates at 255.
    fmode[1] = 3;
    pulse_start(1);
    wait_done(1, 700, cyc);
    start[1] = 1'b0;
    chk("sat_err",  1, 32'(err_count[1]), 32'd255);
    chk("sat_ff",   1, 32'(first_fail[1]), 32'h0);
    chk("sat_pass", 1, 32'(pass[1]), 32'h0);
`ifdef PADCHK_FAIL_MASK_EN
    chk("sat_mask", 1, 32'(fail_mask[1]), 32'h001);
`endif
    // Results hold in IDLE.
    repeat (5) @(negedge gclk);
    chk("hold_err", 1, 32'(err_count[1]), 32'd255);
    fmode[1] = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
